// File: rtl/wdt_rst_gen_if.sv
// rtl/wdt_rst_gen_if.sv - control/status bundle between watchdog overflow stage, reset generator and SoC
interface wdt_rst_gen_if;
    logic       ovf_i;
    logic       enable_i;
    logic       kick_i;
    logic       cause_clr_i;
    logic       irq_o;
    logic       wdt_rst_no;
    logic       rst_cause_o;
    logic [7:0] rst_count_o;
    logic       busy_o;

    modport master (
        output ovf_i, enable_i, kick_i, cause_clr_i,
        input  irq_o, wdt_rst_no, rst_cause_o, rst_count_o, busy_o
    );

    modport slave (
        input  ovf_i, enable_i, kick_i, cause_clr_i,
        output irq_o, wdt_rst_no, rst_cause_o, rst_count_o, busy_o
    );
endinterface

// File: rtl/wdt_rst_gen.sv
// rtl/wdt_rst_gen.sv - watchdog reset pulse generator; WDT_RST_GRACE_EN adds the WARN grace phase with irq_o
module wdt_rst_gen #(
    parameter int CNT_WIDTH        = 16,
    parameter int GRACE_CYCLES     = 256,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES   = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    wdt_rst_gen_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WARN, ST_ASSERT, ST_HOLDOFF} state_e;

    localparam logic [CNT_WIDTH-1:0] PULSE_LD = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LD  = CNT_WIDTH'(HOLDOFF_CYCLES - 1);
`ifdef WDT_RST_GRACE_EN
    localparam logic [CNT_WIDTH-1:0] GRACE_LD = CNT_WIDTH'(GRACE_CYCLES - 1);
`else
    localparam int unused_grace = GRACE_CYCLES;
    logic unused_kick;
    assign unused_kick = bus.kick_i;
`endif

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, trig_q, trig;
    logic                 irq_q, irq_d;
    logic                 rst_n_q, rst_n_d;
    logic                 cause_q, cause_d;
    logic [7:0]           count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 enter_assert;

    // Edge is captured only while idle so late edges in HOLDOFF cannot leak into IDLE.
    assign trig = bus.ovf_i & ~ovf_q & bus.enable_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_q && bus.enable_i) begin
`ifdef WDT_RST_GRACE_EN
                    state_d = ST_WARN;
                    cnt_d   = GRACE_LD;
`else
                    state_d = ST_ASSERT;
                    cnt_d   = PULSE_LD;
`endif
                end
            end
`ifdef WDT_RST_GRACE_EN
            ST_WARN: begin
                if (bus.kick_i || !bus.enable_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ASSERT;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
`endif
            ST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        enter_assert = (state_d == ST_ASSERT) && (state_q != ST_ASSERT);
        irq_d        = (state_d == ST_WARN);
        rst_n_d      = (state_d != ST_ASSERT);
        busy_d       = (state_d != ST_IDLE);
        cause_d      = enter_assert ? 1'b1 : (bus.cause_clr_i ? 1'b0 : cause_q);
        count_d      = (enter_assert && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            trig_q  <= 1'b0;
            irq_q   <= 1'b0;
            rst_n_q <= 1'b1;
            cause_q <= 1'b0;
            count_q <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= bus.ovf_i;
            trig_q  <= trig && (state_q == ST_IDLE);
            irq_q   <= irq_d;
            rst_n_q <= rst_n_d;
            cause_q <= cause_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

`ifdef WDT_RST_GRACE_EN
    assign bus.irq_o = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
    assign bus.irq_o  = 1'b0;
`endif
    assign bus.wdt_rst_no  = rst_n_q;
    assign bus.rst_cause_o = cause_q;
    assign bus.rst_count_o = count_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_wdt_rst_gen.sv
// tb/tb_wdt_rst_gen.sv - directed self-checking bench for wdt_rst_gen (either WDT_RST_GRACE_EN setting)
module tb_wdt_rst_gen;
    localparam int G = 8;
    localparam int P = 4;
    localparam int H = 4;
`ifdef WDT_RST_GRACE_EN
    localparam int LAT = G + 2;
`else
    localparam int LAT = 2;
`endif
    localparam int BUSY_LAST = LAT + P + H - 1;

    logic clk_i = 1'b0;
    logic rst_ni;
    wdt_rst_gen_if bus ();

    wdt_rst_gen #(
        .CNT_WIDTH(16),
        .GRACE_CYCLES(G),
        .RST_PULSE_CYCLES(P),
        .HOLDOFF_CYCLES(H)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;
    int low_cnt, first_low, irq_cnt, first_irq, busy_last;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic watch(input int n, input int kick_at, input int dis_at,
                         input int clr_at, input bit tog);
        low_cnt = 0; first_low = -1; irq_cnt = 0; first_irq = -1; busy_last = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.wdt_rst_no === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
            if (bus.irq_o === 1'b1) begin
                irq_cnt++;
                if (first_irq < 0) first_irq = i;
            end
            if (bus.busy_o === 1'b1) busy_last = i;
            bus.kick_i      = (i == kick_at);
            bus.cause_clr_i = (i == clr_at);
            if (i == dis_at) bus.enable_i = 1'b0;
            if (tog && i >= LAT && i < BUSY_LAST) bus.ovf_i = ~bus.ovf_i;
        end
        bus.kick_i      = 1'b0;
        bus.cause_clr_i = 1'b0;
    endtask

    task automatic settle();
        bus.ovf_i    = 1'b0;
        bus.enable_i = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        rst_ni          = 1'b0;
        bus.ovf_i       = 1'b0;
        bus.enable_i    = 1'b1;
        bus.kick_i      = 1'b0;
        bus.cause_clr_i = 1'b0;
        repeat (2) tick();
        check("rst_rst_n", bus.wdt_rst_no, 1);
        check("rst_irq", bus.irq_o, 0);
        check("rst_cause", bus.rst_cause_o, 0);
        check("rst_count", bus.rst_count_o, 0);
        check("rst_busy", bus.busy_o, 0);
        rst_ni = 1'b1;
        tick();

        // Basic trigger: latency, pulse width, holdoff, sticky flags
        bus.ovf_i = 1'b1;
        watch(BUSY_LAST + 4, -1, -1, -1, 1'b0);
        exp_count++;
        check("basic_first_low", first_low, LAT);
        check("basic_low_cnt", low_cnt, P);
        check("basic_busy_last", busy_last, BUSY_LAST);
`ifdef WDT_RST_GRACE_EN
        check("basic_irq_cnt", irq_cnt, G);
        check("basic_first_irq", first_irq, 2);
`else
        check("basic_irq_cnt", irq_cnt, 0);
`endif
        check("basic_cause", bus.rst_cause_o, 1);
        check("basic_count", bus.rst_count_o, exp_count);
        settle();

        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        check("clr_alone", bus.rst_cause_o, 0);

`ifdef WDT_RST_GRACE_EN
        bus.ovf_i = 1'b1;
        watch(BUSY_LAST + 4, 4, -1, -1, 1'b0);
        check("kick3_low_cnt", low_cnt, 0);
        check("kick3_irq_cnt", irq_cnt, 3);
        check("kick3_busy_last", busy_last, 4);
        check("kick3_count", bus.rst_count_o, exp_count);
        settle();

        bus.ovf_i = 1'b1;
        watch(BUSY_LAST + 4, LAT - 1, -1, -1, 1'b0);
        check("kick0_low_cnt", low_cnt, 0);
        check("kick0_irq_cnt", irq_cnt, G);
        check("kick0_count", bus.rst_count_o, exp_count);
        settle();

        bus.ovf_i = 1'b1;
        watch(BUSY_LAST + 4, -1, 5, -1, 1'b0);
        check("dis_warn_low_cnt", low_cnt, 0);
        check("dis_warn_busy_last", busy_last, 5);
        settle();

        bus.ovf_i = 1'b1;
        watch(BUSY_LAST + 4, -1, LAT + 1, -1, 1'b0);
        exp_count++;
        check("dis_assert_low_cnt", low_cnt, P);
        check("dis_assert_count", bus.rst_count_o, exp_count);
        settle();
`endif

        // Held level: one pulse only
        bus.ovf_i = 1'b1;
        watch(100, -1, -1, -1, 1'b0);
        exp_count++;
        check("held_low_cnt", low_cnt, P);
        check("held_count", bus.rst_count_o, exp_count);
        settle();

        // ovf toggling during ASSERT/HOLDOFF ignored
        bus.ovf_i = 1'b1;
        watch(BUSY_LAST + 8, -1, -1, -1, 1'b1);
        exp_count++;
        bus.ovf_i = 1'b0;
        repeat (BUSY_LAST + 4) tick();
        check("toggle_low_cnt", low_cnt, P);
        check("toggle_count", bus.rst_count_o, exp_count);
        check("toggle_busy_after", bus.busy_o, 0);
        settle();

        // Clear coincident with set: set wins
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        check("clr_before_coinc", bus.rst_cause_o, 0);
        bus.ovf_i = 1'b1;
        watch(LAT + 1, -1, -1, LAT - 1, 1'b0);
        exp_count++;
        check("coinc_cause", bus.rst_cause_o, 1);
        repeat (BUSY_LAST) tick();
        settle();

        // Asynchronous reset mid-pulse
        bus.ovf_i = 1'b1;
        repeat (LAT + 1) tick();
        check("pre_async_low", bus.wdt_rst_no, 0);
        #2;
        rst_ni    = 1'b0;
        bus.ovf_i = 1'b0;
        #1;
        check("async_rst_n", bus.wdt_rst_no, 1);
        check("async_count", bus.rst_count_o, 0);
        check("async_cause", bus.rst_cause_o, 0);
        check("async_busy", bus.busy_o, 0);
        check("async_irq", bus.irq_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Saturation of the reset counter
        for (int i = 1; i <= 260; i++) begin
            bus.ovf_i = 1'b1;
            repeat (BUSY_LAST + 1) tick();
            bus.ovf_i = 1'b0;
            tick();
            if (i == 254) check("sat_254", bus.rst_count_o, 254);
            if (i == 255) check("sat_255", bus.rst_count_o, 255);
        end
        check("sat_260", bus.rst_count_o, 255);
        check("sat_rst_n_idle", bus.wdt_rst_no, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
